// File: rtl/control_pkg.sv
// Shared decode types: control bundle carried from IF/ID to EX, immediate
// format selectors and branch funct3 encodings.
package control_pkg;

    localparam logic [2:0] IMM_I = 3'd1;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;
    localparam logic [2:0] IMM_J = 3'd5;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regwen;
        logic       memread;
        logic       branch;
        logic [2:0] imm_sel;
        logic [3:0] alu_op;
    } control_signals_t;

endpackage

// File: rtl/decode_regfile.sv
// Architectural register file with two combinational read ports and an
// optional same-cycle writeback bypass; x0 is hardwired to zero.
module decode_regfile #(
    parameter int unsigned  XLEN      = 32,
    parameter int unsigned  NREGS     = 32,
    parameter int unsigned  BYPASS_WB = 1,
    localparam int unsigned AW        = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            wb_regwen,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_regwen && wb_rd != '0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        rs1_data = regs[rs1_addr];
        if (BYPASS_WB != 0 && wb_regwen && wb_rd == rs1_addr && rs1_addr != '0) begin
            rs1_data = wb_data;
        end
    end

    always_comb begin
        rs2_data = regs[rs2_addr];
        if (BYPASS_WB != 0 && wb_regwen && wb_rd == rs2_addr && rs2_addr != '0) begin
            rs2_data = wb_data;
        end
    end

endmodule

// File: rtl/decode_pipe.sv
// ID stage: operand read with WB bypass, immediate generation, branch
// compare, load-use interlock and the ID/EX register with valid/ready.
module decode_pipe
    import control_pkg::*;
#(
    parameter int unsigned  XLEN           = 32,
    parameter int unsigned  NREGS          = 32,
    parameter int unsigned  BYPASS_WB      = 1,
    parameter int unsigned  LOAD_USE_STALL = 1,
    parameter int unsigned  CNT_W          = 16,
    localparam int unsigned AW             = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc,
    input  control_signals_t ctrl_in,
    input  logic [AW-1:0]    wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             wb_regwen,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output control_signals_t out_ctrl,
    output logic [XLEN-1:0]  out_rs1,
    output logic [XLEN-1:0]  out_rs2,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_take_branch,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;
    logic            cmp;
    logic            take_branch;
    logic            hazard;
    logic            accept;
    logic            unused_opcode;

    // Opcode bits are decoded upstream into ctrl_in; only immediate fields matter here.
    assign unused_opcode = ^instr[6:0];

    decode_regfile #(
        .XLEN      (XLEN),
        .NREGS     (NREGS),
        .BYPASS_WB (BYPASS_WB)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rs1_addr  (ctrl_in.rs1[AW-1:0]),
        .rs2_addr  (ctrl_in.rs2[AW-1:0]),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_regwen (wb_regwen),
        .rs1_data  (rs1_val),
        .rs2_data  (rs2_val)
    );

    always_comb begin
        imm32 = '0;
        case (ctrl_in.imm_sel)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_ext = XLEN'($signed(imm32));

    always_comb begin
        cmp = 1'b0;
        case (ctrl_in.alu_op[2:0])
            BR_EQ:   cmp = (rs1_val == rs2_val);
            BR_NE:   cmp = (rs1_val != rs2_val);
            BR_LT:   cmp = ($signed(rs1_val) <  $signed(rs2_val));
            BR_GE:   cmp = ($signed(rs1_val) >= $signed(rs2_val));
            BR_LTU:  cmp = (rs1_val <  rs2_val);
            BR_GEU:  cmp = (rs1_val >= rs2_val);
            default: cmp = 1'b0;
        endcase
    end

    assign take_branch = cmp & ctrl_in.branch;

    assign hazard = (LOAD_USE_STALL != 0) && in_valid && out_valid && out_ctrl.memread
                 && (out_ctrl.rd != '0)
                 && (out_ctrl.rd == ctrl_in.rs1 || out_ctrl.rd == ctrl_in.rs2);

    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    // Flush only drops valid; payload is don't-care until the next accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid       <= 1'b0;
            out_pc          <= '0;
            out_ctrl        <= '0;
            out_rs1         <= '0;
            out_rs2         <= '0;
            out_imm         <= '0;
            out_take_branch <= 1'b0;
        end else if (flush) begin
            out_valid       <= 1'b0;
        end else if (accept) begin
            out_valid       <= 1'b1;
            out_pc          <= pc;
            out_ctrl        <= ctrl_in;
            out_rs1         <= rs1_val;
            out_rs2         <= rs2_val;
            out_imm         <= imm_ext;
            out_take_branch <= take_branch;
        end else if (out_ready) begin
            out_valid       <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (hazard && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: one bypassing instance and one without
// bypass share stimulus; expected values are hand-computed constants.
module tb_decode_pipe;
    import control_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [31:0]      instr;
    logic [31:0]      pc;
    control_signals_t ctrl_in;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data;
    logic             wb_regwen;
    logic             out_ready;

    logic             in_ready,  nb_in_ready;
    logic             out_valid, nb_out_valid;
    logic [31:0]      out_pc,    nb_out_pc;
    control_signals_t out_ctrl,  nb_out_ctrl;
    logic [31:0]      out_rs1,   nb_out_rs1;
    logic [31:0]      out_rs2,   nb_out_rs2;
    logic [31:0]      out_imm,   nb_out_imm;
    logic             out_take_branch, nb_out_take_branch;
    logic [15:0]      stall_cnt, nb_stall_cnt;

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    decode_pipe #(.BYPASS_WB(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .ctrl_in(ctrl_in), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_regwen(wb_regwen), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_ctrl(out_ctrl), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_take_branch(out_take_branch), .stall_cnt(stall_cnt)
    );

    decode_pipe #(.BYPASS_WB(0)) dut_nb (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(nb_in_ready),
        .instr(instr), .pc(pc), .ctrl_in(ctrl_in), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_regwen(wb_regwen), .out_valid(nb_out_valid), .out_ready(out_ready),
        .out_pc(nb_out_pc), .out_ctrl(nb_out_ctrl), .out_rs1(nb_out_rs1), .out_rs2(nb_out_rs2),
        .out_imm(nb_out_imm), .out_take_branch(nb_out_take_branch), .stall_cnt(nb_stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic control_signals_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [4:0] rd, input logic memread,
                                            input logic branch, input logic [2:0] imm_sel,
                                            input logic [3:0] alu_op);
        control_signals_t c;
        c.rs1     = rs1;
        c.rs2     = rs2;
        c.rd      = rd;
        c.regwen  = (rd != 5'd0);
        c.memread = memread;
        c.branch  = branch;
        c.imm_sel = imm_sel;
        c.alu_op  = alu_op;
        return c;
    endfunction

    task automatic present(input logic [31:0] p, input control_signals_t c, input logic [31:0] iw);
        pc       = p;
        ctrl_in  = c;
        instr    = iw;
        in_valid = 1'b1;
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
        wb_rd     = rd;
        wb_data   = data;
        wb_regwen = 1'b1;
        tick();
        wb_regwen = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; pc = '0; ctrl_in = '0;
        wb_rd = '0; wb_data = '0; wb_regwen = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        check("rst_valid",  64'(out_valid), 64'd0);
        check("rst_pc",     64'(out_pc), 64'd0);
        check("rst_branch", 64'(out_take_branch), 64'd0);
        check("rst_cnt",    64'(stall_cnt), 64'd0);
        rst = 1'b1;

        wb_write(5'd5, 32'h1234);
        wb_write(5'd7, 32'h1111);
        wb_write(5'd1, 32'd5);
        wb_write(5'd2, 32'd5);

        // add x1,x5,x0
        present(32'h100, mk(5'd5, 5'd0, 5'd1, 1'b0, 1'b0, 3'd0, 4'd0), 32'h000280B3);
        #1;
        check("add_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_rs1",   64'(out_rs1), 64'h1234);
        check("add_rs2",   64'(out_rs2), 64'd0);
        check("add_pc",    64'(out_pc), 64'h100);

        // same-cycle WB of x7 while reading x7
        wb_rd = 5'd7; wb_data = 32'hDEAD; wb_regwen = 1'b1;
        present(32'h104, mk(5'd7, 5'd0, 5'd8, 1'b0, 1'b0, 3'd0, 4'd0), 32'h0);
        tick();
        wb_regwen = 1'b0;
        check("bypass_rs1",   64'(out_rs1), 64'hDEAD);
        check("nobypass_rs1", 64'(nb_out_rs1), 64'h1111);

        // beq x1,x2,-8 with x1 = x2 = 5
        present(32'h108, mk(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, IMM_B, {1'b0, BR_EQ}), 32'hFE208CE3);
        tick();
        check("beq_take", 64'(out_take_branch), 64'd1);
        check("beq_imm",  64'(out_imm), 64'hFFFFFFF8);

        in_valid = 1'b0;
        wb_write(5'd1, 32'hFFFFFFFF);
        wb_write(5'd2, 32'd1);

        present(32'h10C, mk(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, IMM_B, {1'b0, BR_LTU}), 32'h0);
        tick();
        check("bltu_take", 64'(out_take_branch), 64'd0);
        present(32'h110, mk(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, IMM_B, {1'b0, BR_LT}), 32'h0);
        #1;
        check("b2b_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("blt_take", 64'(out_take_branch), 64'd1);
        check("blt_pc",   64'(out_pc), 64'h110);

        // addi x9,x0,-4 while WB tries to write x0
        wb_rd = 5'd0; wb_data = 32'hBEEF; wb_regwen = 1'b1;
        present(32'h114, mk(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, IMM_I, 4'd0), 32'hFFC00493);
        tick();
        wb_regwen = 1'b0;
        check("immi",       64'(out_imm), 64'hFFFFFFFC);
        check("x0_bypass",  64'(out_rs1), 64'd0);
        present(32'h118, mk(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, IMM_U, 4'd0), 32'h123454B7);
        tick();
        check("immu",      64'(out_imm), 64'h12345000);
        check("x0_stored", 64'(out_rs1), 64'd0);

        // lw x3 followed by add x4,x3,x3
        present(32'h11C, mk(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, IMM_I, 4'd0), 32'h0);
        tick();
        present(32'h120, mk(5'd3, 5'd3, 5'd4, 1'b0, 1'b0, 3'd0, 4'd0), 32'h0);
        #1;
        check("lu_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("lu_bubble",   64'(out_valid), 64'd0);
        check("lu_cnt",      64'(stall_cnt), 64'd1);
        check("lu_release",  64'(in_ready), 64'd1);
        tick();
        check("lu_add_valid", 64'(out_valid), 64'd1);
        check("lu_add_pc",    64'(out_pc), 64'h120);
        check("lu_cnt_hold",  64'(stall_cnt), 64'd1);

        // EX back-pressure for three cycles
        out_ready = 1'b0;
        present(32'h124, mk(5'd5, 5'd0, 5'd6, 1'b0, 1'b0, 3'd0, 4'd0), 32'h0);
        #1;
        check("bp_in_ready0", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_valid",    64'(out_valid), 64'd1);
            check("bp_pc",       64'(out_pc), 64'h120);
            check("bp_rd",       64'(out_ctrl.rd), 64'd4);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_resume_ready", 64'(in_ready), 64'd1);
        tick();
        check("bp_next_pc",  64'(out_pc), 64'h124);
        check("bp_next_rs1", 64'(out_rs1), 64'h1234);

        // flush coinciding with a load-use hazard
        present(32'h128, mk(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, IMM_I, 4'd0), 32'h0);
        tick();
        present(32'h12C, mk(5'd3, 5'd3, 5'd4, 1'b0, 1'b0, 3'd0, 4'd0), 32'h0);
        flush = 1'b1;
        #1;
        check("fl_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_cnt",   64'(stall_cnt), 64'd2);
        #1;
        check("fl_in_ready_after", 64'(in_ready), 64'd1);
        tick();
        check("fl_reissue_valid", 64'(out_valid), 64'd1);
        check("fl_reissue_pc",    64'(out_pc), 64'h12C);

        // asynchronous reset mid-stream
        present(32'h130, mk(5'd5, 5'd0, 5'd6, 1'b0, 1'b0, 3'd0, 4'd0), 32'h0);
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_pc",    64'(out_pc), 64'd0);
        check("ar_ctrl",  64'(out_ctrl), 64'd0);
        check("ar_cnt",   64'(stall_cnt), 64'd0);
        tick();
        rst = 1'b1;
        present(32'h134, mk(5'd5, 5'd0, 5'd6, 1'b0, 1'b0, 3'd0, 4'd0), 32'h0);
        tick();
        check("ar_rf_valid", 64'(out_valid), 64'd1);
        check("ar_rf_x5",    64'(out_rs1), 64'd0);
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
